// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and entry packing for the fetch queue
package fetch_pkg;

  // Layout of one fetch-to-decode entry: {adef, inst[31:0], pc[31:0]}.
  localparam int FS2DS_LEN      = 65;
  localparam int FS2DS_PC_LSB   = 0;
  localparam int FS2DS_INST_LSB = 32;
  localparam int FS2DS_ADEF_BIT = 64;

  // Instruction fetches are always full 32-bit words.
  localparam logic [1:0] INST_SRAM_SIZE = 2'b10;

  function automatic logic [FS2DS_LEN-1:0] fs2ds_pack(input logic        adef,
                                                      input logic [31:0] inst,
                                                      input logic [31:0] pc);
    logic [FS2DS_LEN-1:0] e;
    e                           = '0;
    e[FS2DS_ADEF_BIT]           = adef;
    e[FS2DS_INST_LSB +: 32]     = inst;
    e[FS2DS_PC_LSB +: 32]       = pc;
    return e;
  endfunction

endpackage

// File: rtl/fetch_sync_fifo.sv
// rtl/fetch_sync_fifo.sv - synchronous FIFO with flush and occupancy count
module fetch_sync_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             empty, full, do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (32'(cnt_q) == DEPTH);
  assign do_pop  = pop_i & ~empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push_i & (~full | do_pop);

  // Empty reads return zero so the consumer never sees stale storage.
  assign rd_data_o = empty ? '0 : mem_q[rd_ptr_q];
  assign count_o   = cnt_q;

  // Pointer and count update; flush wins over push/pop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage write; contents are only observable through the count.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fetch_queue_mo.sv
// rtl/fetch_queue_mo.sv - multi-outstanding instruction fetch front end
module fetch_queue_mo
  import fetch_pkg::*;
#(
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          QUEUE_DEPTH     = 4,
  parameter logic [31:0] RESET_PC        = 32'h1C00_0000
) (
  input  logic                 clk,
  input  logic                 resetn,
  output logic                 inst_sram_req,
  output logic                 inst_sram_wr,
  output logic [1:0]           inst_sram_size,
  output logic [3:0]           inst_sram_wstrb,
  output logic [31:0]          inst_sram_addr,
  output logic [31:0]          inst_sram_wdata,
  input  logic                 inst_sram_addr_ok,
  input  logic                 inst_sram_data_ok,
  input  logic [31:0]          inst_sram_rdata,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  input  logic                 fetch_stall,
  input  logic                 ds_allowin,
  output logic                 fs2ds_valid,
  output logic [FS2DS_LEN-1:0] fs2ds_bus
);

  localparam int IF_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int Q_W  = $clog2(QUEUE_DEPTH + 1);

  logic [31:0]          pf_pc_q, pf_pc_d;
  logic                 halt_q, halt_d;
  logic [IF_W-1:0]      discard_q, discard_d;
  logic [IF_W-1:0]      inflight, inflight_next;
  logic [Q_W-1:0]       occupancy;
  logic [31:0]          head_pc;
  logic [FS2DS_LEN-1:0] q_head, q_push_data;
  logic                 misaligned, q_full, accept, data_keep, adef_push, q_push, q_pop;

  assign misaligned = (pf_pc_q[1:0] != 2'b00);
  assign q_full     = (32'(occupancy) >= QUEUE_DEPTH);

  // Credits count both in-flight reads and queued entries, so every response has a slot.
  assign inst_sram_req = resetn & ~redirect_valid & ~fetch_stall & ~halt_q & ~misaligned
                       & (32'(inflight) < MAX_OUTSTANDING)
                       & (32'(inflight) + 32'(occupancy) < QUEUE_DEPTH);
  assign accept        = inst_sram_req & inst_sram_addr_ok;
  assign inflight_next = inflight + IF_W'(accept) - IF_W'(inst_sram_data_ok);

  // Responses are stale while discard_cnt is non-zero, and always in a redirect cycle.
  assign data_keep = inst_sram_data_ok & (discard_q == '0) & ~redirect_valid;
  // The address-error entry waits until every older valid response has landed.
  assign adef_push = misaligned & ~halt_q & (inflight == discard_q) & ~q_full & ~redirect_valid;
  assign q_push      = data_keep | adef_push;
  assign q_push_data = adef_push ? fs2ds_pack(1'b1, 32'h0, pf_pc_q)
                                 : fs2ds_pack(1'b0, inst_sram_rdata, head_pc);
  assign q_pop       = fs2ds_valid & ds_allowin & ~redirect_valid;

  assign fs2ds_valid     = (occupancy != '0);
  assign fs2ds_bus       = q_head;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = INST_SRAM_SIZE;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;
  assign inst_sram_addr  = pf_pc_q;

  // PCs of accepted requests; its count is the in-flight counter.
  fetch_sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (accept),
    .push_data_i (pf_pc_q),
    .pop_i       (inst_sram_data_ok),
    .flush_i     (1'b0),
    .rd_data_o   (head_pc),
    .count_o     (inflight)
  );

  // Instruction queue feeding decode; emptied on redirect.
  fetch_sync_fifo #(.WIDTH(FS2DS_LEN), .DEPTH(QUEUE_DEPTH)) u_inst_queue (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (q_push),
    .push_data_i (q_push_data),
    .pop_i       (q_pop),
    .flush_i     (redirect_valid),
    .rd_data_o   (q_head),
    .count_o     (occupancy)
  );

  // Next fetch pc, halt flag and stale-response count.
  always_comb begin
    pf_pc_d   = pf_pc_q;
    halt_d    = halt_q;
    discard_d = discard_q;
    if (redirect_valid) begin
      pf_pc_d   = redirect_pc;
      halt_d    = 1'b0;
      discard_d = inflight_next;
    end else begin
      if (accept)    pf_pc_d = pf_pc_q + 32'd4;
      if (adef_push) halt_d  = 1'b1;
      if (inst_sram_data_ok && discard_q != '0) discard_d = discard_q - IF_W'(1);
    end
  end

  // Front-end state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pf_pc_q   <= RESET_PC;
      halt_q    <= 1'b0;
      discard_q <= '0;
    end else begin
      pf_pc_q   <= pf_pc_d;
      halt_q    <= halt_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue_mo.sv
// tb/tb_fetch_queue_mo.sv - randomized self-checking bench for fetch_queue_mo
module tb_fetch_queue_mo;

  localparam int          MO     = 2;
  localparam int          QD     = 4;
  localparam logic [31:0] RST_PC = 32'h1C00_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_stall, ds_allowin;
  logic        fs2ds_valid;
  logic [64:0] fs2ds_bus;

  fetch_queue_mo #(.MAX_OUTSTANDING(MO), .QUEUE_DEPTH(QD), .RESET_PC(RST_PC)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .fetch_stall       (fetch_stall),
    .ds_allowin        (ds_allowin),
    .fs2ds_valid       (fs2ds_valid),
    .fs2ds_bus         (fs2ds_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // SRAM model: in-order responses, each ready a few cycles after acceptance.
  logic [31:0] pend_pc[$];
  int          pend_rdy[$];
  int          cyc = 0;
  int          lat_min = 1, lat_max = 1;
  int          cfg_aok = 100, cfg_allow = 100, cfg_stall = 0, cfg_redir = 0;
  bit          redir_now = 0;
  logic [31:0] redir_target;

  // Expected architectural stream: sequential pcs from the last redirect target.
  logic [31:0] exp_req_pc, exp_bus_pc;
  bit          mis_mode = 0, adef_seen = 0;
  int          accepted = 0, dequeued = 0, max_out = 0;

  task automatic sample();
    if (redirect_valid) check_eq("req_in_redirect", inst_sram_req, 1'b0);
    if (mis_mode)       check_eq("req_while_halted", inst_sram_req, 1'b0);
    if (inst_sram_req)  check_eq("req_outstanding_cap", pend_pc.size() < MO, 1'b1);
    if (inst_sram_req && inst_sram_addr_ok) begin
      check_eq("req_addr", inst_sram_addr, exp_req_pc);
      pend_pc.push_back(inst_sram_addr);
      pend_rdy.push_back(cyc + $urandom_range(lat_max, lat_min));
      exp_req_pc += 32'd4;
      accepted++;
    end
    if (pend_pc.size() > max_out) max_out = pend_pc.size();
    if (inst_sram_data_ok) begin
      void'(pend_pc.pop_front());
      void'(pend_rdy.pop_front());
    end
    if (fs2ds_valid && ds_allowin && !redirect_valid) begin
      dequeued++;
      if (mis_mode) begin
        if (!adef_seen) check_eq("adef_entry", fs2ds_bus, {1'b1, 32'h0, exp_bus_pc});
        else            check_eq("extra_after_adef", fs2ds_valid, 1'b0);
        adef_seen = 1;
      end else begin
        check_eq("bus_entry", fs2ds_bus, {1'b0, sram_word(exp_bus_pc), exp_bus_pc});
        exp_bus_pc += 32'd4;
      end
    end
    if (redirect_valid) begin
      exp_req_pc = redirect_pc;
      exp_bus_pc = redirect_pc;
      mis_mode   = (redirect_pc[1:0] != 2'b00);
      adef_seen  = 0;
    end
  endtask

  task automatic step();
    logic [31:0] off;
    @(posedge clk);
    #1;
    cyc++;
    if (redir_now) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_target;
      redir_now      = 0;
    end else if ($urandom_range(99) < cfg_redir) begin
      off            = 32'($urandom_range(1023));
      if ($urandom_range(7) != 0) off[1:0] = 2'b00;
      redirect_valid = 1'b1;
      redirect_pc    = RST_PC + off;
    end else begin
      redirect_valid = 1'b0;
    end
    fetch_stall = ($urandom_range(99) < cfg_stall);
    ds_allowin  = ($urandom_range(99) < cfg_allow);
    if (pend_pc.size() > 0 && pend_rdy[0] <= cyc) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = sram_word(pend_pc[0]);
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = $urandom;
    end
    #1;
    inst_sram_addr_ok = ($urandom_range(99) < cfg_aok);
    #1;
    sample();
  endtask

  initial begin
    resetn = 1'b0;
    inst_sram_addr_ok = 0; inst_sram_data_ok = 0; inst_sram_rdata = 0;
    redirect_valid = 0; redirect_pc = 0; fetch_stall = 0; ds_allowin = 1;
    exp_req_pc = RST_PC;
    exp_bus_pc = RST_PC;
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_req", inst_sram_req, 1'b0);
    check_eq("rst_valid", fs2ds_valid, 1'b0);
    check_eq("rst_bus", fs2ds_bus, 65'h0);
    check_eq("rst_addr", inst_sram_addr, RST_PC);
    check_eq("const_size", inst_sram_size, 2'b10);
    check_eq("const_wr", {inst_sram_wr, inst_sram_wstrb, inst_sram_wdata}, 37'h0);
    resetn = 1'b1;

    // Fixed 1-cycle latency, decode always ready: one request and one entry per cycle.
    for (int i = 0; i < 30; i++) begin
      step();
      if (i == 0) check_eq("first_req_addr", {inst_sram_req, inst_sram_addr}, {1'b1, RST_PC});
      if (i >= 3) check_eq("b2b_req", inst_sram_req, 1'b1);
      if (i >= 3) check_eq("b2b_valid", fs2ds_valid, 1'b1);
    end

    // Latency 5: outstanding cap must be reached and respected.
    lat_min = 5; lat_max = 5; max_out = 0;
    repeat (40) step();
    check_eq("max_outstanding_hit", max_out, MO);

    // Drain, then hold decode for 20 cycles: exactly QD requests fill the queue.
    cfg_stall = 100;
    repeat (15) step();
    lat_min = 1; lat_max = 1; cfg_stall = 0; cfg_allow = 0; accepted = 0;
    repeat (20) step();
    check_eq("hold_accepted", accepted, QD);
    check_eq("hold_req_low", inst_sram_req, 1'b0);
    check_eq("hold_valid", fs2ds_valid, 1'b1);
    cfg_allow = 100; cfg_stall = 100; dequeued = 0;
    repeat (6) step();
    check_eq("hold_drained", dequeued, QD);

    // Single request: data_ok at t, entry visible at t+1 but not at t.
    cfg_stall = 0; accepted = 0;
    step();
    check_eq("lat_accept", accepted, 1);
    cfg_stall = 100;
    step();
    check_eq("lat_data_ok", inst_sram_data_ok, 1'b1);
    check_eq("lat_no_bypass", fs2ds_valid, 1'b0);
    step();
    check_eq("lat_visible", fs2ds_valid, 1'b1);

    // Redirect with two reads in flight: both responses dropped.
    cfg_stall = 0; lat_min = 5; lat_max = 5;
    for (int k = 0; k < 20 && pend_pc.size() < 2; k++) step();
    check_eq("two_inflight", pend_pc.size(), 2);
    redir_now = 1; redir_target = 32'h1C00_0100;
    step();
    dequeued = 0;
    repeat (20) step();
    check_eq("redir_progress", dequeued > 0, 1'b1);

    // Misaligned target: one adef entry, no SRAM traffic until the next redirect.
    redir_now = 1; redir_target = 32'h1C00_0102;
    repeat (15) step();
    check_eq("adef_seen", adef_seen, 1'b1);
    redir_now = 1; redir_target = 32'h1C00_0200;
    step();
    step();
    check_eq("redir_next_req", {inst_sram_req, inst_sram_addr}, {1'b1, 32'h1C00_0200});

    // Redirect coincident with data_ok and ds_allowin.
    lat_min = 1; lat_max = 1;
    repeat (6) step();
    redir_now = 1; redir_target = 32'h1C00_0300;
    step();
    check_eq("coinc_data_ok", inst_sram_data_ok, 1'b1);
    step();
    check_eq("coinc_empty", fs2ds_valid, 1'b0);
    check_eq("coinc_req", {inst_sram_req, inst_sram_addr}, {1'b1, 32'h1C00_0300});

    // Randomized traffic.
    cfg_redir = 2;
    for (int blk = 0; blk < 40; blk++) begin
      lat_min   = 1;
      lat_max   = $urandom_range(6, 1);
      cfg_aok   = $urandom_range(100, 30);
      cfg_allow = $urandom_range(100, 20);
      cfg_stall = $urandom_range(30, 0);
      repeat (50) step();
    end

    cfg_redir = 0; cfg_stall = 100; cfg_allow = 100; cfg_aok = 100;
    repeat (30) step();
    check_eq("final_empty", fs2ds_valid, 1'b0);
    check_eq("final_no_pending", pend_pc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
